// File: rtl/wr_burst_arbiter.sv
// wr_burst_arbiter: round-robin arbiter sharing one FIFO write port, each grant a burst sized from free FIFO space.
module wr_burst_arbiter #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4,
  parameter int NREQ = 4,
  parameter int BURST = 4
) (
  input  logic                   wr_clk_i,
  input  logic                   aclr_i,
  input  logic [NREQ-1:0]        req_valid_i,
  input  logic [NREQ*DWIDTH-1:0] req_data_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic                   wr_full_i,
  input  logic [AWIDTH-1:0]      wr_usedw_i,
  output logic                   wr_req_o,
  output logic [DWIDTH-1:0]      wr_data_o,
  output logic [NREQ-1:0]        grant_o,
  output logic                   busy_o
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = AWIDTH + 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_BURST = 2'd1, S_SETTLE = 2'd2;
  logic [1:0]    state;
  logic [PW-1:0] rr_ptr, pick_idx;
  logic [CW-1:0] credit, free, burst_cap;
  logic          settle_cnt, pick_found, cur_valid, ready_g, hs, burst_end;
  always_comb begin
    free = wr_full_i ? '0 : CW'(2**AWIDTH) - CW'(wr_usedw_i);
    burst_cap = CW'(BURST) < free ? CW'(BURST) : free;
    cur_valid = req_valid_i[rr_ptr];
    ready_g = state == S_BURST && credit != '0 && !wr_full_i;
    hs = ready_g && cur_valid;
    burst_end = (hs && credit == CW'(1)) || !cur_valid || wr_full_i;
    req_ready_o = ready_g ? NREQ'(1) << rr_ptr : '0;
    busy_o = state != S_IDLE;
    pick_found = 1'b0;
    pick_idx = '0;
    // search upward from the last winner so every requester gets its turn
    for (int i = 1; i <= NREQ; i++) begin
      if (!pick_found && free != '0 && req_valid_i[(int'(rr_ptr) + i) % NREQ]) begin
        pick_found = 1'b1;
        pick_idx = PW'((int'(rr_ptr) + i) % NREQ);
      end
    end
  end
  always_ff @(posedge wr_clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      state <= S_IDLE;
      rr_ptr <= PW'(NREQ - 1);
      credit <= '0;
      grant_o <= '0;
      wr_req_o <= 1'b0;
      wr_data_o <= '0;
      settle_cnt <= 1'b0;
    end else begin
      wr_req_o <= hs;
      if (hs) wr_data_o <= req_data_i[rr_ptr*DWIDTH +: DWIDTH];
      if (state == S_IDLE && pick_found) begin
        state <= S_BURST;
        grant_o <= NREQ'(1) << pick_idx;
        rr_ptr <= pick_idx;
        credit <= burst_cap;
      end else if (state == S_BURST) begin
        if (hs) credit <= credit - CW'(1);
        if (burst_end) begin
          state <= S_SETTLE;
          grant_o <= '0;
          settle_cnt <= 1'b0;
        end
      end else if (state == S_SETTLE) begin
        // two settle cycles let the FIFO's usedw catch up with the last write
        settle_cnt <= 1'b1;
        if (settle_cnt) state <= S_IDLE;
      end
    end
  end
endmodule
